inst_encoder: RTL and testbench

Instruction encoder for the single-cycle RISC-V flow. It is the inverse of the immediate generator: it accepts instruction fields plus a 64-bit sign-extended immediate and packs them into a 32-bit I-, S- or SB-format instruction word. Each word is delivered with its instruction-memory byte address over a valid/ready stream. Used by the instruction-memory loader and by the round-trip checker.

---
 rtl/inst_encoder.sv | 107 ++++++++++
 tb/tb_inst_encoder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// Packs I/S/SB instruction fields and a sign-extended immediate into a 32-bit word with its byte address.
// The immediate range check is built only when INST_ENC_RANGE_CHECK_EN is defined.
module inst_encoder #(
  parameter int unsigned       ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [63:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic              err_sticky,
  input  logic              err_clear,
  output logic [31:0]       out_count
);

  localparam int unsigned INST_W = 32;
  localparam int unsigned IMM_W  = 64;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned FLD_W  = 12;

  logic [ADDR_W-1:0] next_addr;
  logic [FLD_W-1:0]  imm12;
  logic [INST_W-1:0] enc_inst_c;
  logic              imm_err_c;
  logic              in_fire;
  logic              out_fire;

  assign in_ready = !restart && (!out_valid || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign imm12    = in_imm[FLD_W-1:0];

  // Field packing; opcode[6:5] picks the format, 10 and 11 both map to SB.
  always_comb begin
    enc_inst_c = '0;
    case (in_opcode[6:5])
      2'b00:   enc_inst_c = {imm12, in_rs1, in_funct3, in_rd, in_opcode};
      2'b01:   enc_inst_c = {imm12[11:5], in_rs2, in_rs1, in_funct3, imm12[4:0], in_opcode};
      default: enc_inst_c = {imm12[11], imm12[9:4], in_rs2, in_rs1, in_funct3,
                             imm12[3:0], imm12[10], in_opcode};
    endcase
  end

`ifdef INST_ENC_RANGE_CHECK_EN
  // In range when every bit above bit 10 matches the sign bit.
  assign imm_err_c = !((&in_imm[IMM_W-1:FLD_W-1]) || !(|in_imm[IMM_W-1:FLD_W-1]));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_sticky <= 1'b0;
    end else if (in_fire && imm_err_c) begin
      err_sticky <= 1'b1;
    end else if (err_clear) begin
      err_sticky <= 1'b0;
    end
  end
`else
  logic unused_no_check;

  assign imm_err_c       = 1'b0;
  assign err_sticky      = 1'b0;
  assign unused_no_check = ^{in_imm[IMM_W-1:FLD_W], err_clear};
`endif

  // Single output register stage plus the running address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_addr  <= BASE_ADDR;
      out_err   <= 1'b0;
      next_addr <= BASE_ADDR;
    end else if (restart) begin
      out_valid <= 1'b0;
      next_addr <= BASE_ADDR;
    end else if (in_fire) begin
      out_valid <= 1'b1;
      out_inst  <= enc_inst_c;
      out_addr  <= next_addr;
      out_err   <= imm_err_c;
      next_addr <= next_addr + ADDR_W'(4);
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_count <= '0;
    end else if (out_fire) begin
      out_count <= out_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed vector table, multi-cycle corner sequences and a random stream
// checked against an arithmetic encoder/decoder model with a scoreboard queue.
module tb_inst_encoder;

  localparam int unsigned       ADDR_W = 64;
  localparam logic [ADDR_W-1:0] BASE   = '0;
`ifdef INST_ENC_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] imm;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [31:0] exp_inst;
    bit          oor;
  } tv_t;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] addr;
    bit          err;
    logic [63:0] imm;
    bit          in_range;
  } exp_t;

  logic              clk;
  logic              reset_n;
  logic              restart;
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        in_opcode;
  logic [2:0]        in_funct3;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [63:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;
  logic              err_sticky;
  logic              err_clear;
  logic [31:0]       out_count;

  int          n_chk;
  int          n_err;
  exp_t        q[$];
  logic [63:0] m_addr;
  logic [31:0] m_count;
  bit          m_sticky;
  tv_t         tbl[8];

  inst_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset_n(reset_n), .restart(restart),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_addr(out_addr), .out_err(out_err), .err_sticky(err_sticky),
    .err_clear(err_clear), .out_count(out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit in_rng(input logic [63:0] imm);
    return ($signed(imm) >= -64'sd2048) && ($signed(imm) <= 64'sd2047);
  endfunction

  // Reference encoder: places each field by multiplying with its bit weight.
  function automatic logic [31:0] model_enc(input vec_t x);
    longint unsigned i12, w, base;
    i12  = x.imm % 64'd4096;
    base = 64'(x.rs1) * 64'h8000 + 64'(x.funct3) * 64'h1000 + 64'(x.opcode);
    case (x.opcode[6:5])
      2'b00:   w = i12 * 64'h10_0000 + 64'(x.rd) * 64'h80 + base;
      2'b01:   w = (i12 / 32) * 64'h200_0000 + 64'(x.rs2) * 64'h10_0000
                   + (i12 % 32) * 64'h80 + base;
      default: w = (i12 / 2048) * 64'h8000_0000 + ((i12 / 16) % 64) * 64'h200_0000
                   + 64'(x.rs2) * 64'h10_0000 + (i12 % 16) * 64'h100
                   + ((i12 / 1024) % 2) * 64'h80 + base;
    endcase
    return 32'(w);
  endfunction

  // Immediate generator view of a word, used for the round-trip property.
  function automatic logic [63:0] dec_imm(input logic [31:0] w);
    logic [11:0] f;
    case (w[6:5])
      2'b00:   f = w[31:20];
      2'b01:   f = {w[31:25], w[11:7]};
      default: f = {w[31], w[7], w[30:25], w[11:8]};
    endcase
    return {{52{f[11]}}, f};
  endfunction

  function automatic tv_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [63:0] imm,
                             input logic [31:0] exp_inst, input bit oor);
    tv_t t;
    t.v.opcode = op; t.v.funct3 = f3; t.v.rd = rd;
    t.v.rs1 = rs1; t.v.rs2 = rs2; t.v.imm = imm;
    t.exp_inst = exp_inst; t.oor = oor;
    return t;
  endfunction

  function automatic vec_t rnd_vec();
    vec_t x;
    logic [11:0] s;
    x.opcode = 7'($urandom);
    x.funct3 = 3'($urandom);
    x.rd     = 5'($urandom);
    x.rs1    = 5'($urandom);
    x.rs2    = 5'($urandom);
    s        = 12'($urandom);
    case ($urandom_range(0, 3))
      0:       x.imm = {$urandom, $urandom};
      1:       x.imm = {{52{s[11]}}, ~s[11], s[10:0]};
      default: x.imm = {{52{s[11]}}, s};
    endcase
    return x;
  endfunction

  // One cycle: drive at the falling edge, compare against the model, then advance the model.
  task automatic step(input bit v, input vec_t x, input bit ordy, input bit rst_p, input bit clr);
    bit   o_fire, i_fire, exp_rdy;
    exp_t e;
    @(negedge clk);
    in_valid = v; out_ready = ordy; restart = rst_p; err_clear = clr;
    in_opcode = x.opcode; in_funct3 = x.funct3; in_rd = x.rd;
    in_rs1 = x.rs1; in_rs2 = x.rs2; in_imm = x.imm;
    #1;
    exp_rdy = !rst_p && (q.size() == 0 || ordy);
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("err_sticky", 64'(err_sticky), 64'(m_sticky));
    chk("out_count", 64'(out_count), 64'(m_count));
    if (q.size() != 0) begin
      chk("out_inst", 64'(out_inst), 64'(q[0].inst));
      chk("out_addr", out_addr, q[0].addr);
      chk("out_err", 64'(out_err), 64'(q[0].err));
      if (q[0].in_range) chk("round_trip", dec_imm(out_inst), q[0].imm);
    end
    o_fire = (q.size() != 0) && ordy;
    i_fire = v && exp_rdy;
    if (o_fire) begin
      m_count++;
      void'(q.pop_front());
    end
    if (rst_p) begin
      q.delete();
      m_addr = BASE;
    end
    if (i_fire) begin
      e.inst = model_enc(x); e.addr = m_addr; e.imm = x.imm;
      e.in_range = in_rng(x.imm); e.err = RC && !e.in_range;
      q.push_back(e);
      m_addr = m_addr + 64'd4;
    end
    if (i_fire && RC && !in_rng(x.imm)) m_sticky = 1'b1;
    else if (clr && RC) m_sticky = 1'b0;
  endtask

  initial begin
    vec_t idle;
    n_chk = 0; n_err = 0;
    m_addr = BASE; m_count = '0; m_sticky = 1'b0;
    reset_n = 1'b0; restart = 1'b0; in_valid = 1'b0; out_ready = 1'b0; err_clear = 1'b0;
    in_opcode = '0; in_funct3 = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    idle = '0;

    tbl[0] = mk(7'b0000011, 3'b011, 5'd5, 5'd2, 5'd0, 64'hFFFF_FFFF_FFFF_FFF8, 32'hFF81_3283, 1'b0);
    tbl[1] = mk(7'b0100011, 3'b011, 5'd0, 5'd2, 5'd5, 64'd16,                  32'h0051_3823, 1'b0);
    tbl[2] = mk(7'b1100011, 3'b000, 5'd0, 5'd1, 5'd2, 64'd4,                   32'h0020_8463, 1'b0);
    tbl[3] = mk(7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 64'd2047,                32'h7FF0_0093, 1'b0);
    tbl[4] = mk(7'b0100011, 3'b010, 5'd0, 5'd3, 5'd4, 64'hFFFF_FFFF_FFFF_F800, 32'h8041_A023, 1'b0);
    tbl[5] = mk(7'b1100011, 3'b001, 5'd0, 5'd5, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFE62_9FE3, 1'b0);
    tbl[6] = mk(7'b0000011, 3'b000, 5'd1, 5'd1, 5'd0, 64'h800,                 32'h8000_8083, 1'b1);
    tbl[7] = mk(7'b1110011, 3'b000, 5'd0, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_F7FF, 32'h7E00_0FF3, 1'b1);

    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_inst", 64'(out_inst), 64'd0);
    chk("rst_out_addr", out_addr, BASE);
    chk("rst_out_err", 64'(out_err), 64'd0);
    chk("rst_err_sticky", 64'(err_sticky), 64'd0);
    chk("rst_out_count", 64'(out_count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed vectors, one word every two cycles.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, tbl[i].v, 1'b1, 1'b0, 1'b0);
      step(1'b0, tbl[i].v, 1'b1, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_inst", i), 64'(out_inst), 64'(tbl[i].exp_inst));
      chk($sformatf("tbl%0d_addr", i), out_addr, BASE + 64'(i) * 64'd4);
      chk($sformatf("tbl%0d_err", i), 64'(out_err), 64'(RC && tbl[i].oor));
    end
    chk("sticky_after_tbl", 64'(err_sticky), 64'(RC));
    step(1'b0, idle, 1'b1, 1'b0, 1'b1);
    step(1'b0, idle, 1'b1, 1'b0, 1'b0);
    chk("sticky_cleared", 64'(err_sticky), 64'd0);
    step(1'b1, tbl[6].v, 1'b1, 1'b0, 1'b1);
    step(1'b0, idle, 1'b1, 1'b0, 1'b0);
    chk("sticky_set_wins", 64'(err_sticky), 64'(RC));

    // Asynchronous reset while a word is held.
    step(1'b1, tbl[0].v, 1'b0, 1'b0, 1'b0);
    step(1'b0, tbl[0].v, 1'b0, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset_out_valid", 64'(out_valid), 64'd0);
    chk("areset_out_addr", out_addr, BASE);
    chk("areset_out_count", 64'(out_count), 64'd0);
    chk("areset_sticky", 64'(err_sticky), 64'd0);
    q.delete(); m_addr = BASE; m_count = '0; m_sticky = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Backpressure: three words offered while the consumer stalls for four cycles.
    step(1'b1, tbl[0].v, 1'b0, 1'b0, 1'b0);
    repeat (4) step(1'b1, tbl[1].v, 1'b0, 1'b0, 1'b0);
    chk("bp_hold_inst", 64'(out_inst), 64'h0000_0000_FF81_3283);
    chk("bp_hold_addr", out_addr, BASE);
    step(1'b1, tbl[1].v, 1'b1, 1'b0, 1'b0);
    step(1'b1, tbl[2].v, 1'b1, 1'b0, 1'b0);
    chk("bp_addr2", out_addr, BASE + 64'd4);
    step(1'b0, idle, 1'b1, 1'b0, 1'b0);
    chk("bp_addr3", out_addr, BASE + 64'd8);
    step(1'b0, idle, 1'b1, 1'b0, 1'b0);
    chk("bp_count", 64'(out_count), 64'd3);

    // Restart with a held word and a valid input in the same cycle.
    step(1'b1, tbl[3].v, 1'b0, 1'b0, 1'b0);
    step(1'b1, tbl[4].v, 1'b0, 1'b0, 1'b0);
    step(1'b1, tbl[4].v, 1'b0, 1'b1, 1'b0);
    step(1'b0, idle, 1'b1, 1'b0, 1'b0);
    chk("restart_drop", 64'(out_valid), 64'd0);
    step(1'b1, tbl[5].v, 1'b1, 1'b0, 1'b0);
    step(1'b0, idle, 1'b1, 1'b0, 1'b0);
    chk("restart_addr", out_addr, BASE);
    chk("restart_inst", 64'(out_inst), 64'(tbl[5].exp_inst));

    // Random stream with random stalls, restarts and clears.
    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 9) < 7, rnd_vec(), $urandom_range(0, 9) < 7,
           $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5);
    end
    repeat (3) step(1'b0, idle, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
